// File: rtl/bank_data_router_pkg.sv
// Shared constants for the bank data router: bank-select and local-address widths.
package bank_data_router_pkg;

  function automatic int bank_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_width(input int num_banks);
    return bank_log2(num_banks);
  endfunction

  function automatic int local_width(input int addr_width, input int num_banks);
    return addr_width - bank_log2(num_banks);
  endfunction

endpackage

// File: rtl/bank_data_router_if.sv
// Upstream write request plus flattened per-bank request bus of the bank data router.
interface bank_data_router_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 4
) ();
  import bank_data_router_pkg::*;

  localparam int SEL_W   = sel_width(NUM_BANKS);
  localparam int LOCAL_W = local_width(ADDR_WIDTH, NUM_BANKS);

  logic                            i_valid;
  logic                            o_ready;
  logic [ADDR_WIDTH-1:0]           i_addr;
  logic [DATA_WIDTH-1:0]           i_data;
  logic [NUM_BANKS-1:0]            o_bank_valid;
  logic [NUM_BANKS-1:0]            i_bank_ready;
  logic [NUM_BANKS*LOCAL_W-1:0]    o_bank_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] o_bank_data;
  logic [SEL_W:0]                  o_pending;

  modport slave (
    input  i_valid, i_addr, i_data, i_bank_ready,
    output o_ready, o_bank_valid, o_bank_addr, o_bank_data, o_pending
  );

  modport master (
    output i_valid, i_addr, i_data, i_bank_ready,
    input  o_ready, o_bank_valid, o_bank_addr, o_bank_data, o_pending
  );
endinterface

// File: rtl/bank_data_router_slot.sv
// One-entry bank slot: load wins over drain, so a same-cycle drain+refill keeps valid high.
module bank_slot #(
  parameter int LOCAL_W    = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  drain,
  input  logic [LOCAL_W-1:0]    load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  vld,
  output logic [LOCAL_W-1:0]    addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/bank_data_router.sv
// Routes write requests to per-bank one-entry slots selected by the top address bits.
module bank_data_router
  import bank_data_router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  bank_data_router_if.slave bus
);

  localparam int SEL_W   = sel_width(NUM_BANKS);
  localparam int LOCAL_W = local_width(ADDR_WIDTH, NUM_BANKS);
  localparam int PEND_W  = SEL_W + 1;

  logic [SEL_W-1:0]                      sel;
  logic [LOCAL_W-1:0]                    loc;
  logic                                  ready;
  logic                                  accept;
  logic [NUM_BANKS-1:0]                  slot_vld;
  logic [NUM_BANKS-1:0]                  load;
  logic [NUM_BANKS-1:0]                  drain;
  logic [NUM_BANKS-1:0]                  nxt_vld;
  logic [NUM_BANKS-1:0][LOCAL_W-1:0]     slot_addr;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  slot_data;
  logic [NUM_BANKS*LOCAL_W-1:0]          addr_flat;
  logic [NUM_BANKS*DATA_WIDTH-1:0]       data_flat;
  logic [PEND_W-1:0]                     pend_nxt;
  logic [PEND_W-1:0]                     pend_q;

  assign sel    = bus.i_addr[ADDR_WIDTH-1 -: SEL_W];
  assign loc    = bus.i_addr[LOCAL_W-1:0];
  // Combinational from i_addr/i_bank_ready: a draining slot can be refilled in the same cycle.
  assign ready  = !slot_vld[sel] || bus.i_bank_ready[sel];
  assign accept = bus.i_valid && ready;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    assign load[k]  = accept && (sel == SEL_W'(k));
    assign drain[k] = slot_vld[k] && bus.i_bank_ready[k];

    bank_slot #(
      .LOCAL_W    (LOCAL_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .load      (load[k]),
      .drain     (drain[k]),
      .load_addr (loc),
      .load_data (bus.i_data),
      .vld       (slot_vld[k]),
      .addr      (slot_addr[k]),
      .data      (slot_data[k])
    );
  end

  // Empty slots present zeros so stale contents never leak onto the bank bus.
  always_comb begin
    addr_flat = '0;
    data_flat = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (slot_vld[k]) begin
        addr_flat[k*LOCAL_W +: LOCAL_W]       = slot_addr[k];
        data_flat[k*DATA_WIDTH +: DATA_WIDTH] = slot_data[k];
      end
    end
  end

  // Occupancy tracks the slot valids exactly, computed from their next-state values.
  always_comb begin
    nxt_vld  = load | (slot_vld & ~drain);
    pend_nxt = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      pend_nxt = pend_nxt + PEND_W'(nxt_vld[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pend_q <= '0;
    else          pend_q <= pend_nxt;
  end

  assign bus.o_ready      = ready;
  assign bus.o_bank_valid = slot_vld;
  assign bus.o_bank_addr  = addr_flat;
  assign bus.o_bank_data  = data_flat;
  assign bus.o_pending    = pend_q;

endmodule
